pll_reconfig_ctrl: RTL and testbench
====================================

Name: pll_reconfig_ctrl

Overview:
- Supervisor and dynamic-reconfiguration controller for a Gowin rPLL run with DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL enabled.
- Runs on the board reference clock (27 MHz crystal), never on PLL output. Drives the PLL reset and divider selects, then qualifies LOCK.
- Releases a downstream active-low reset only after lock is stable. Retries failed locks and accepts runtime divider changes via valid/ready.

Parameters:
RST_CYCLES, 16, cycles pll_reset is held high per (re)configuration attempt
LOCK_TIMEOUT, 27000, cycles to wait for synchronised lock before an attempt fails (1 ms at 27 MHz)
LOCK_STABLE, 2700, consecutive synchronised-lock cycles required before declaring locked
MAX_RETRY, 3, failed attempts per configuration before entering FAIL
INIT_IDIV, 0, IDIV_SEL applied after reset
INIT_FBDIV, 2, FBDIV_SEL applied after reset (27 MHz -> 81 MHz)
INIT_ODIV, 8, ODIV_SEL code applied after reset

Ports:
clk  in  1  reference clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  new divider configuration offered
req_ready  out  1  controller accepts a configuration this cycle
req_idiv  in  6  requested IDIV_SEL
req_fbdiv  in  6  requested FBDIV_SEL
req_odiv  in  6  requested ODIV_SEL code
pll_lock  in  1  rPLL LOCK, asynchronous
pll_reset  out  1  rPLL RESET
pll_idsel  out  6  rPLL IDSEL = ~idiv
pll_fbdsel  out  6  rPLL FBDSEL = ~fbdiv
pll_odsel  out  6  rPLL ODSEL = ~odiv
locked  out  1  PLL configured and lock qualified
clk_rst_n  out  1  active-low reset for PLL-clocked logic; equals locked
err  out  1  sticky: MAX_RETRY attempts failed for current configuration

Behaviour:
- All outputs registered. Reset (rst_n=0 at edge): state=APPLY pending, cfg=INIT_*, pll_reset=1, selects=~INIT_*, locked=0, clk_rst_n=0, err=0, req_ready=0, retry=0, counters=0.
- pll_lock passes through a 2-FF synchroniser to give lock_s. All lock decisions use lock_s.
- APPLY:
  - selects driven from captured cfg on the first APPLY cycle.
  - pll_reset=1 for exactly RST_CYCLES cycles, then 0.
  - Next state WAIT_LOCK, with the timeout counter cleared.
- WAIT_LOCK:
  - lock_s=1 -> STABLE, stable counter cleared.
  - Timeout counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> retry+1.
  - If the new retry == MAX_RETRY -> FAIL; else -> APPLY with the same cfg.
- STABLE:
  - Counts consecutive lock_s=1 cycles.
  - lock_s=0 -> WAIT_LOCK with the timeout counter restarted. Retry count unchanged.
  - After LOCK_STABLE cycles -> LOCKED. locked and clk_rst_n go 1 on the same edge; retry cleared.
- LOCKED:
  - req_ready=1. On req_valid&&req_ready, capture req_* into cfg.
  - Next edge: locked=0, clk_rst_n=0, err=0, retry=0, -> APPLY.
  - lock_s=0 (lock loss) -> locked=0 and clk_rst_n=0 next edge, -> WAIT_LOCK without pll_reset.
  - If accept and lock loss occur together, accept wins.
- FAIL:
  - err=1, locked=0, clk_rst_n=0, pll_reset=1 held, req_ready=1.
  - Accepting a request clears err and retry, -> APPLY with the new cfg.
  - Without a request, FAIL holds forever.
- req_ready=0 in APPLY, WAIT_LOCK and STABLE. req_valid is ignored there; the requester must hold it.
- rst_n low in any state, including mid-APPLY or mid-STABLE, restores reset values on that edge. Any captured request is discarded.
- Counter widths are $clog2 of the respective parameter (min 1). There is no wrap: counters clear on every state entry.
- Divider legality is not checked; codes pass through inverted.

Test Plan:
- Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=64, LOCK_STABLE=8, MAX_RETRY=2.
- Power-up: release rst_n, assert pll_lock 10 cycles later -> pll_reset high exactly 4 cycles after release; pll_fbdsel=6'h3D, pll_odsel=6'h37, pll_idsel=6'h3F; locked and clk_rst_n rise on the 11th edge after pll_lock rises; req_ready=1.
- Reconfigure from LOCKED: req_fbdiv=5, req_odiv=4, req_idiv=0 accepted in one cycle -> locked=0 next edge; pll_fbdsel=6'h3A, pll_odsel=6'h3B; 4-cycle pll_reset pulse; relock as in the power-up case.
- Lock glitch in STABLE: drop pll_lock 1 cycle after 5 stable cycles -> STABLE restarts and locked is delayed; no pll_reset pulse; err=0.
- Timeout to FAIL: pll_lock held 0 -> two APPLY pulses, each 64 wait cycles apart; err=1; req_ready=1; pll_reset stays 1. A new request then clears err and restarts APPLY.
- Lock loss in LOCKED: drop pll_lock -> clk_rst_n=0 within 3 edges; no pll_reset; restore lock -> relock after LOCK_STABLE cycles.
- Busy and reset: req_valid during WAIT_LOCK -> req_ready=0, not captured. rst_n pulse during APPLY cycle 2 -> all outputs return to reset values and the APPLY sequence restarts from INIT_*.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
//   Supervisor and dynamic-reconfiguration controller for a Gowin rPLL with
//   dynamic IDIV/FBDIV/ODIV selects. Runs on the reference clock. It pulses the
//   PLL reset, drives the inverted divider selects, qualifies the synchronised
//   LOCK, and releases the downstream reset once lock has been stable. Failed
//   lock attempts are retried. After MAX_RETRY failures the controller parks in
//   FAIL. New divider settings are accepted through a valid/ready handshake.
//
// Ports
//   clk                     reference clock
//   rst_n                   synchronous active-low reset
//   req_valid / req_ready   configuration handshake
//   req_idiv/fbdiv/odiv     requested divider codes
//   pll_lock                rPLL LOCK (asynchronous)
//   pll_reset               rPLL RESET
//   pll_idsel/fbdsel/odsel  inverted divider codes for the rPLL
//   locked                  configured and lock qualified
//   clk_rst_n               active-low reset for PLL-clocked logic (= locked)
//   err                     sticky retry-exhausted flag
module pll_reconfig_ctrl #(
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_TIMEOUT = 27000,
  parameter int         LOCK_STABLE  = 2700,
  parameter int         MAX_RETRY    = 3,
  parameter logic [5:0] INIT_IDIV    = 6'd0,
  parameter logic [5:0] INIT_FBDIV   = 6'd2,
  parameter logic [5:0] INIT_ODIV    = 6'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idiv,
  input  logic [5:0] req_fbdiv,
  input  logic [5:0] req_odiv,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       locked,
  output logic       clk_rst_n,
  output logic       err
);

  // One shared counter: every state clears it on entry, so it only has to
  // cover the longest interval of the three.
  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int CNT_MAX   = (LOCK_TIMEOUT > CNT_MAX_A) ? LOCK_TIMEOUT : CNT_MAX_A;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    ST_APPLY  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [RETRY_W-1:0] retry_r, retry_s;
  logic [5:0]         cfg_idiv_r, cfg_idiv_s;
  logic [5:0]         cfg_fbdiv_r, cfg_fbdiv_s;
  logic [5:0]         cfg_odiv_r, cfg_odiv_s;
  logic               lock_meta_r, lock_sync_r;
  logic               accept_s;
  logic               pll_reset_s, locked_s, err_s, ready_s;
  logic [5:0]         idsel_s, fbdsel_s, odsel_s;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_lock;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    retry_s     = retry_r;
    cfg_idiv_s  = cfg_idiv_r;
    cfg_fbdiv_s = cfg_fbdiv_r;
    cfg_odiv_s  = cfg_odiv_r;
    pll_reset_s = pll_reset;
    idsel_s     = pll_idsel;
    fbdsel_s    = pll_fbdsel;
    odsel_s     = pll_odsel;
    locked_s    = locked;
    err_s       = err;
    ready_s     = req_ready;
    accept_s    = req_valid && req_ready;

    case (state_r)
      ST_APPLY: begin
        idsel_s  = ~cfg_idiv_r;
        fbdsel_s = ~cfg_fbdiv_r;
        odsel_s  = ~cfg_odiv_r;
        if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
          state_s     = ST_WAIT;
          cnt_s       = {CNT_W{1'b0}};
          pll_reset_s = 1'b0;
        end else begin
          cnt_s       = cnt_r + CNT_W'(1);
          pll_reset_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (lock_sync_r) begin
          state_s = ST_STABLE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_s     = retry_r + RETRY_W'(1);
          cnt_s       = {CNT_W{1'b0}};
          pll_reset_s = 1'b1;
          if (retry_s == RETRY_W'(MAX_RETRY)) begin
            state_s = ST_FAIL;
            err_s   = 1'b1;
            ready_s = 1'b1;
          end else begin
            state_s = ST_APPLY;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_sync_r) begin
          // A dropout restarts qualification without another PLL reset.
          state_s = ST_WAIT;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(LOCK_STABLE - 1)) begin
          state_s  = ST_LOCKED;
          cnt_s    = {CNT_W{1'b0}};
          retry_s  = {RETRY_W{1'b0}};
          locked_s = 1'b1;
          ready_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_LOCKED, ST_FAIL: begin
        // Accept is checked first so it takes priority over a lock loss.
        if (accept_s) begin
          state_s     = ST_APPLY;
          cnt_s       = {CNT_W{1'b0}};
          retry_s     = {RETRY_W{1'b0}};
          cfg_idiv_s  = req_idiv;
          cfg_fbdiv_s = req_fbdiv;
          cfg_odiv_s  = req_odiv;
          idsel_s     = ~req_idiv;
          fbdsel_s    = ~req_fbdiv;
          odsel_s     = ~req_odiv;
          pll_reset_s = 1'b1;
          locked_s    = 1'b0;
          err_s       = 1'b0;
          ready_s     = 1'b0;
        end else if (state_r == ST_LOCKED && !lock_sync_r) begin
          state_s  = ST_WAIT;
          cnt_s    = {CNT_W{1'b0}};
          locked_s = 1'b0;
          ready_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s     = ST_APPLY;
        cnt_s       = {CNT_W{1'b0}};
        pll_reset_s = 1'b1;
        locked_s    = 1'b0;
        ready_s     = 1'b0;
      end
    endcase
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_APPLY;
      cnt_r       <= {CNT_W{1'b0}};
      retry_r     <= {RETRY_W{1'b0}};
      cfg_idiv_r  <= INIT_IDIV;
      cfg_fbdiv_r <= INIT_FBDIV;
      cfg_odiv_r  <= INIT_ODIV;
      pll_reset   <= 1'b1;
      pll_idsel   <= ~INIT_IDIV;
      pll_fbdsel  <= ~INIT_FBDIV;
      pll_odsel   <= ~INIT_ODIV;
      locked      <= 1'b0;
      clk_rst_n   <= 1'b0;
      err         <= 1'b0;
      req_ready   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      retry_r     <= retry_s;
      cfg_idiv_r  <= cfg_idiv_s;
      cfg_fbdiv_r <= cfg_fbdiv_s;
      cfg_odiv_r  <= cfg_odiv_s;
      pll_reset   <= pll_reset_s;
      pll_idsel   <= idsel_s;
      pll_fbdsel  <= fbdsel_s;
      pll_odsel   <= odsel_s;
      locked      <= locked_s;
      clk_rst_n   <= locked_s;
      err         <= err_s;
      req_ready   <= ready_s;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl
//   Self-checking bench for pll_reconfig_ctrl. Expected outputs come from an
//   edge-arithmetic model: an APPLY that starts on edge E holds pll_reset for
//   RST edges, lock seen on edge k+3 after pll_lock rises after edge k, and
//   locked follows LOCK_STABLE edges later; timeouts repeat every RST+TO edges.
module tb_pll_reconfig_ctrl;

  localparam int RST   = 4;
  localparam int TO    = 64;
  localparam int STB   = 8;
  localparam int MR    = 2;
  localparam int NEVER = 1 << 30;
  localparam logic [5:0] INIT_I = 6'd0;
  localparam logic [5:0] INIT_F = 6'd2;
  localparam logic [5:0] INIT_O = 6'd8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_idiv, req_fbdiv, req_odiv;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       locked, clk_rst_n, err;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  pll_reconfig_ctrl #(
    .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .LOCK_STABLE(STB), .MAX_RETRY(MR),
    .INIT_IDIV(INIT_I), .INIT_FBDIV(INIT_F), .INIT_ODIV(INIT_O)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idiv(req_idiv), .req_fbdiv(req_fbdiv), .req_odiv(req_odiv),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .locked(locked), .clk_rst_n(clk_rst_n), .err(err)
  );

  always #5 clk = ~clk;

  // Edge counter: after step() returns, cyc is the number of the last edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Edge on which locked rises after an APPLY started on apply_edge and
  // pll_lock was driven high just after edge lock_rise.
  function automatic int relock_at(input int apply_edge, input int lock_rise);
    int seen;
    seen = lock_rise + 3;
    if (seen < apply_edge + RST + 1) seen = apply_edge + RST + 1;
    return seen + STB;
  endfunction

  // Step n edges checking the status outputs against the model windows.
  task automatic run_win(input int n, input int loss, input int relock,
                         input int rlo, input int rhi);
    logic lk;
    for (int i = 0; i < n; i++) begin
      step();
      lk = (cyc < loss) || (cyc >= relock);
      chk("pll_reset", pll_reset, (cyc >= rlo) && (cyc < rhi));
      chk("locked", locked, lk);
      chk("clk_rst_n", clk_rst_n, lk);
      chk("req_ready", req_ready, lk);
      chk("err", err, 6'd0);
    end
  endtask

  task automatic chk_sels(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
    chk("pll_idsel", pll_idsel, ~i);
    chk("pll_fbdsel", pll_fbdsel, ~f);
    chk("pll_odsel", pll_odsel, ~o);
  endtask

  task automatic chk_reset_state();
    chk("rst_pll_reset", pll_reset, 6'd1);
    chk_sels(INIT_I, INIT_F, INIT_O);
    chk("rst_locked", locked, 6'd0);
    chk("rst_clk_rst_n", clk_rst_n, 6'd0);
    chk("rst_err", err, 6'd0);
    chk("rst_req_ready", req_ready, 6'd0);
  endtask

  // Offer a configuration while ready; it is accepted on the next edge.
  task automatic offer(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
    chk("ready_before_offer", req_ready, 6'd1);
    req_idiv = i; req_fbdiv = f; req_odiv = o; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("accept_locked", locked, 6'd0);
    chk("accept_clk_rst_n", clk_rst_n, 6'd0);
    chk("accept_pll_reset", pll_reset, 6'd1);
    chk("accept_err", err, 6'd0);
    chk("accept_req_ready", req_ready, 6'd0);
    chk_sels(i, f, o);
  endtask

  // From an APPLY start on edge a, raise pll_lock d edges later and follow relock.
  task automatic relock_after_apply(input int a, input int d);
    int rl;
    run_win(d - (cyc - a), 0, NEVER, a, a + RST);
    pll_lock = 1'b1;
    rl = relock_at(a, cyc);
    run_win(rl - cyc + 3, 0, rl, a, a + RST);
  endtask

  initial begin
    int a, g, h, r, rl, t;
    logic [5:0] ci, cf, co, bi, bf, bo;

    rst_n = 1'b0; req_valid = 1'b0; pll_lock = 1'b0;
    req_idiv = 6'd0; req_fbdiv = 6'd0; req_odiv = 6'd0;
    repeat (3) step();
    chk_reset_state();

    // Power-up: lock arrives 10 edges after reset release.
    a = cyc;
    rst_n = 1'b1;
    relock_after_apply(a, 10);
    chk_sels(6'd0, 6'd2, 6'd8);

    // Directed reconfiguration, then several random ones.
    offer(6'd0, 6'd5, 6'd4);
    a = cyc;
    pll_lock = 1'b0;
    chk("fbdsel_directed", pll_fbdsel, 6'h3A);
    chk("odsel_directed", pll_odsel, 6'h3B);
    relock_after_apply(a, 10);
    for (int k = 0; k < 3; k++) begin
      ci = 6'($urandom); cf = 6'($urandom); co = 6'($urandom);
      offer(ci, cf, co);
      a = cyc;
      pll_lock = 1'b0;
      relock_after_apply(a, int'($urandom_range(5, 30)));
      chk_sels(ci, cf, co);
    end

    // One-cycle lock glitch after five stable cycles.
    offer(6'($urandom), 6'($urandom), 6'($urandom));
    a = cyc;
    pll_lock = 1'b0;
    run_win(int'($urandom_range(5, 30)), 0, NEVER, a, a + RST);
    pll_lock = 1'b1;
    g = cyc + 8;
    rl = relock_at(a, g + 1);
    run_win(8, 0, rl, a, a + RST);
    pll_lock = 1'b0;
    run_win(1, 0, rl, a, a + RST);
    pll_lock = 1'b1;
    run_win(rl - cyc + 3, 0, rl, a, a + RST);

    // Lock loss while locked, restored r edges later.
    g = cyc;
    r = int'($urandom_range(3, 10));
    h = g + r;
    pll_lock = 1'b0;
    run_win(r, g + 3, h + 11, 0, 0);
    pll_lock = 1'b1;
    run_win(14, g + 3, h + 11, 0, 0);

    // Busy: a request held during APPLY/WAIT_LOCK is not taken.
    ci = 6'($urandom); cf = 6'($urandom); co = 6'($urandom);
    offer(ci, cf, co);
    a = cyc;
    pll_lock = 1'b0;
    run_win(6, 0, NEVER, a, a + RST);
    bi = ~ci; bf = ~cf; bo = 6'($urandom);
    req_idiv = bi; req_fbdiv = bf; req_odiv = bo; req_valid = 1'b1;
    run_win(5, 0, NEVER, a, a + RST);
    req_valid = 1'b0;
    relock_after_apply(a, 15);
    chk_sels(ci, cf, co);

    // Timeout: lock never returns; MR attempts, then FAIL.
    offer(6'($urandom), 6'($urandom), 6'($urandom));
    a = cyc;
    pll_lock = 1'b0;
    for (int k = 0; k < MR * (RST + TO) + 12; k++) begin
      step();
      t = cyc - a;
      chk("to_pll_reset", pll_reset, (t >= MR * (RST + TO)) || ((t % (RST + TO)) < RST));
      chk("to_err", err, t >= MR * (RST + TO));
      chk("to_req_ready", req_ready, t >= MR * (RST + TO));
      chk("to_locked", locked, 6'd0);
    end

    // A request in FAIL clears err and restarts APPLY.
    ci = 6'($urandom); cf = 6'($urandom); co = 6'($urandom);
    offer(ci, cf, co);
    a = cyc;
    relock_after_apply(a, int'($urandom_range(5, 30)));
    chk_sels(ci, cf, co);

    // Reset pulse during the second APPLY cycle restores INIT values.
    offer(6'($urandom), 6'($urandom), 6'($urandom));
    pll_lock = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk_reset_state();
    a = cyc;
    rst_n = 1'b1;
    relock_after_apply(a, 10);
    chk_sels(INIT_I, INIT_F, INIT_O);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
